// File: rtl/median_pkg.sv
// Shared types and sizes for the 3x3 median merge stage.
// Optional feature macro: MEDIAN_MINMAX_EN (adds window min/max outputs).
package median_pkg;

    localparam int unsigned DSIZE     = 8;
    localparam int unsigned WIN_COLS  = 3;
    localparam int unsigned COL_CNT_W = 2;

    typedef logic [DSIZE-1:0]     sample_t;
    typedef logic [COL_CNT_W-1:0] cnt_t;

    // One pre-sorted column of the window.
    typedef struct packed {
        sample_t hi;
        sample_t mid;
        sample_t lo;
    } col_t;

    localparam cnt_t CNT_ONE  = COL_CNT_W'(1);
    localparam cnt_t CNT_FULL = COL_CNT_W'(WIN_COLS);

    // Unsigned "a >= b" expressed as !(a < b), no width growth.
    function automatic logic ge(input sample_t a, input sample_t b);
        return !(a < b);
    endfunction

endpackage

// File: rtl/median_3x3_merge_if.sv
// Column-in / median-out bus between the column sorter and the pixel stage.
// Optional feature macro: MEDIAN_MINMAX_EN (adds out_min/out_max).
interface median_3x3_merge_if;
    import median_pkg::*;

    logic    in_valid;
    logic    in_sol;
    sample_t in_hi;
    sample_t in_mid;
    sample_t in_lo;

    logic    out_valid;
    sample_t out_median;
`ifdef MEDIAN_MINMAX_EN
    sample_t out_min;
    sample_t out_max;
`endif

    // Upstream side: drives columns, observes results.
    modport master (
        output in_valid, in_sol, in_hi, in_mid, in_lo,
`ifdef MEDIAN_MINMAX_EN
        input  out_min, out_max,
`endif
        input  out_valid, out_median
    );

    // Merge stage side: consumes columns, produces results.
    modport slave (
        input  in_valid, in_sol, in_hi, in_mid, in_lo,
`ifdef MEDIAN_MINMAX_EN
        output out_min, out_max,
`endif
        output out_valid, out_median
    );

endinterface

// File: rtl/sort3_net.sv
// Combinational 3-input sorting network giving max/median/min.
// Optional feature macro: MEDIAN_MINMAX_EN (not used here).
module sort3_net
    import median_pkg::*;
(
    input  sample_t a,
    input  sample_t b,
    input  sample_t c,
    output sample_t mx,
    output sample_t md,
    output sample_t mn
);

    sample_t ab_hi;
    sample_t ab_lo;
    sample_t hi_c_lo;

    // Order a/b, then merge c: med = max(min(a,b), min(max(a,b), c)).
    always_comb begin
        ab_hi   = ge(a, b) ? a : b;
        ab_lo   = ge(a, b) ? b : a;
        mx      = ge(ab_hi, c) ? ab_hi : c;
        mn      = ge(ab_lo, c) ? c : ab_lo;
        hi_c_lo = ge(ab_hi, c) ? c : ab_hi;
        md      = ge(ab_lo, hi_c_lo) ? ab_lo : hi_c_lo;
    end

endmodule

// File: rtl/median_3x3_merge.sv
// 3x3 median from a stream of pre-sorted columns; two-edge result pipeline.
// Optional feature macro: MEDIAN_MINMAX_EN (also registers window min/max).
module median_3x3_merge
    import median_pkg::*;
(
    input  logic               clock,
    input  logic               rst,
    median_3x3_merge_if.slave  bus
);

    col_t    win [WIN_COLS];
    col_t    in_col;
    cnt_t    col_cnt;
    cnt_t    cnt_next;
    logic    full_c;
    logic    v1;
    logic    v2;

    sample_t lo_mx, lo_md, lo_mn;
    sample_t mid_mx, mid_md, mid_mn;
    sample_t hi_mx, hi_md, hi_mn;
    sample_t fin_mx, fin_md, fin_mn;

    sample_t a_r;
    sample_t b_r;
    sample_t c_r;
`ifdef MEDIAN_MINMAX_EN
    sample_t mn_r;
    sample_t mx_r;
`endif

    // Next column count: in_sol restarts at 1, otherwise saturate at full.
    always_comb begin
        cnt_next = col_cnt;
        in_col   = '{hi: bus.in_hi, mid: bus.in_mid, lo: bus.in_lo};
        if (bus.in_sol) begin
            cnt_next = CNT_ONE;
        end else if (col_cnt != CNT_FULL) begin
            cnt_next = col_cnt + CNT_ONE;
        end
        full_c = (cnt_next == CNT_FULL);
    end

    // Window shift register, column count and first valid flag.
    always_ff @(posedge clock) begin
        if (rst) begin
            win[0]  <= '0;
            win[1]  <= '0;
            win[2]  <= '0;
            col_cnt <= '0;
            v1      <= 1'b0;
        end else begin
            v1 <= bus.in_valid && full_c;
            if (bus.in_valid) begin
                win[2]  <= win[1];
                win[1]  <= win[0];
                win[0]  <= in_col;
                col_cnt <= cnt_next;
            end
        end
    end

    sort3_net u_lows (
        .a  (win[0].lo),
        .b  (win[1].lo),
        .c  (win[2].lo),
        .mx (lo_mx),
        .md (lo_md),
        .mn (lo_mn)
    );

    sort3_net u_mids (
        .a  (win[0].mid),
        .b  (win[1].mid),
        .c  (win[2].mid),
        .mx (mid_mx),
        .md (mid_md),
        .mn (mid_mn)
    );

    sort3_net u_highs (
        .a  (win[0].hi),
        .b  (win[1].hi),
        .c  (win[2].hi),
        .mx (hi_mx),
        .md (hi_md),
        .mn (hi_mn)
    );

    // Stage 1: max-of-lows, median-of-mids, min-of-highs.
    always_ff @(posedge clock) begin
        if (rst) begin
            v2  <= 1'b0;
            a_r <= '0;
            b_r <= '0;
            c_r <= '0;
`ifdef MEDIAN_MINMAX_EN
            mn_r <= '0;
            mx_r <= '0;
`endif
        end else begin
            v2 <= v1;
            if (v1) begin
                a_r <= lo_mx;
                b_r <= mid_md;
                c_r <= hi_mn;
`ifdef MEDIAN_MINMAX_EN
                mn_r <= lo_mn;
                mx_r <= hi_mx;
`endif
            end
        end
    end

    sort3_net u_final (
        .a  (a_r),
        .b  (b_r),
        .c  (c_r),
        .mx (fin_mx),
        .md (fin_md),
        .mn (fin_mn)
    );

    // Stage 2: median of the three partial results; data held between pulses.
    always_ff @(posedge clock) begin
        if (rst) begin
            bus.out_valid  <= 1'b0;
            bus.out_median <= '0;
`ifdef MEDIAN_MINMAX_EN
            bus.out_min    <= '0;
            bus.out_max    <= '0;
`endif
        end else begin
            bus.out_valid <= v2;
            if (v2) begin
                bus.out_median <= fin_md;
`ifdef MEDIAN_MINMAX_EN
                bus.out_min    <= mn_r;
                bus.out_max    <= mx_r;
`endif
            end
        end
    end

    // Network outputs not needed by this configuration.
    logic unused_net;
`ifdef MEDIAN_MINMAX_EN
    assign unused_net = ^{lo_md, mid_mx, mid_mn, hi_md, fin_mx, fin_mn};
`else
    assign unused_net = ^{lo_md, lo_mn, mid_mx, mid_mn, hi_mx, hi_md, fin_mx, fin_mn};
`endif

endmodule

// File: tb/tb_median_3x3_merge.sv
// Randomized self-checking bench for median_3x3_merge against a 9-value sort model.
// Optional feature macro: MEDIAN_MINMAX_EN (also checks out_min/out_max).
module tb_median_3x3_merge;
    import median_pkg::*;

    typedef struct {
        int unsigned due;
        int          med;
        int          mn;
        int          mx;
    } exp_t;

    typedef struct {
        int hi;
        int mid;
        int lo;
    } tcol_t;

    logic        clk = 1'b0;
    logic        rst;
    int          n_tests = 0;
    int          n_fail  = 0;
    int unsigned cyc     = 0;

    exp_t  pend [$];
    tcol_t line_q [$];
    int    line_n = 0;

    median_3x3_merge_if bus ();

    median_3x3_merge dut (
        .clock (clk),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    // Reference: keep the current line's last three columns, sort all nine values.
    task automatic model_col(input int hi, input int mid, input int lo, input bit sol);
        int   vals [$];
        exp_t e;
        if (sol) begin
            line_q.delete();
            line_n = 0;
        end
        line_q.push_back('{hi: hi, mid: mid, lo: lo});
        if (line_q.size() > 3) void'(line_q.pop_front());
        line_n++;
        if (line_n >= 3) begin
            foreach (line_q[i]) begin
                vals.push_back(line_q[i].hi);
                vals.push_back(line_q[i].mid);
                vals.push_back(line_q[i].lo);
            end
            vals.sort();
            e.due = cyc + 3;
            e.med = vals[4];
            e.mn  = vals[0];
            e.mx  = vals[8];
            pend.push_back(e);
        end
    endtask

    // Reset at the coming edge: line forgotten, results not yet shown are lost.
    task automatic model_reset();
        exp_t keep [$];
        line_q.delete();
        line_n = 0;
        foreach (pend[i]) if (pend[i].due < cyc + 1) keep.push_back(pend[i]);
        pend = keep;
    endtask

    task automatic send(input bit v, input bit sol, input int hi, input int mid, input int lo);
        @(negedge clk);
        bus.in_valid = v;
        bus.in_sol   = sol;
        bus.in_hi    = DSIZE'(hi);
        bus.in_mid   = DSIZE'(mid);
        bus.in_lo    = DSIZE'(lo);
        if (v) model_col(hi, mid, lo, sol);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++)
            send(1'b0, 1'($urandom), int'($urandom_range(0, 255)),
                 int'($urandom_range(0, 255)), int'($urandom_range(0, 255)));
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            rst          = 1'b1;
            bus.in_valid = 1'($urandom);
            bus.in_sol   = 1'($urandom);
            bus.in_hi    = DSIZE'($urandom);
            model_reset();
        end
        @(negedge clk);
        rst          = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_sol   = 1'b0;
    endtask

    task automatic send_rand_col(input bit sol);
        int q [$];
        q.push_back(int'($urandom_range(0, 255)));
        q.push_back(int'($urandom_range(0, 255)));
        q.push_back(int'($urandom_range(0, 255)));
        q.sort();
        send(1'b1, sol, q[2], q[1], q[0]);
    endtask

    // Scoreboard: every cycle out_valid must match the model, data when valid.
    always @(negedge clk) begin
        logic exp_v;
        exp_v = (pend.size() > 0) && (pend[0].due == cyc);
        check_eq("out_valid", 32'(bus.out_valid), 32'(exp_v));
        if (exp_v) begin
            check_eq("out_median", 32'(bus.out_median), 32'(pend[0].med));
`ifdef MEDIAN_MINMAX_EN
            check_eq("out_min", 32'(bus.out_min), 32'(pend[0].mn));
            check_eq("out_max", 32'(bus.out_max), 32'(pend[0].mx));
`endif
            void'(pend.pop_front());
        end
    end

    initial begin
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_sol   = 1'b0;
        bus.in_hi    = '0;
        bus.in_mid   = '0;
        bus.in_lo    = '0;

        // Reset: held 3 cycles, then idle with nothing produced.
        do_reset(3);
        for (int i = 0; i < 4; i++) begin
            idle(1);
            check_eq("rst_median", 32'(bus.out_median), 32'd0);
            check_eq("rst_col_cnt", 32'(dut.col_cnt), 32'd0);
        end

        // Basic median.
        send(1'b1, 1'b1, 9, 5, 1);
        send(1'b1, 1'b0, 8, 6, 2);
        send(1'b1, 1'b0, 7, 4, 3);
        idle(4);

        // Back-to-back ties.
        send(1'b1, 1'b1, 4, 4, 4);
        for (int i = 0; i < 4; i++) send(1'b1, 1'b0, 4, 4, 4);
        idle(4);

        // Line restart excludes old columns.
        send(1'b1, 1'b1, 9, 5, 1);
        send(1'b1, 1'b0, 8, 6, 2);
        send(1'b1, 1'b1, 3, 3, 3);
        send(1'b1, 1'b0, 3, 3, 3);
        idle(3);
        send(1'b1, 1'b0, 3, 3, 3);
        idle(4);

        // Gaps between columns.
        send(1'b1, 1'b1, 9, 5, 1);
        idle(2);
        send(1'b1, 1'b0, 8, 6, 2);
        idle(2);
        send(1'b1, 1'b0, 7, 4, 3);
        idle(5);

        // Reset on the edge after the third column, then a line without in_sol.
        send(1'b1, 1'b1, 9, 5, 1);
        send(1'b1, 1'b0, 8, 6, 2);
        send(1'b1, 1'b0, 7, 4, 3);
        do_reset(1);
        send(1'b1, 1'b0, 20, 10, 0);
        send(1'b1, 1'b0, 30, 15, 5);
        send(1'b1, 1'b0, 25, 12, 11);
        idle(4);

        // Random lines with gaps, garbage on idle cycles and occasional resets.
        for (int ln = 0; ln < 60; ln++) begin
            int len;
            bit after_rst;
            after_rst = 1'b0;
            if ($urandom_range(0, 9) == 0) begin
                do_reset(int'($urandom_range(1, 2)));
                after_rst = 1'b1;
            end
            len = int'($urandom_range(1, 7));
            for (int c = 0; c < len; c++) begin
                send_rand_col((c == 0) ? !(after_rst && $urandom_range(0, 1) == 1) : 1'b0);
                if ($urandom_range(0, 3) == 0) idle(int'($urandom_range(1, 2)));
            end
            if ($urandom_range(0, 4) == 0) begin
                send_rand_col(1'b0);
                do_reset(1);
            end
        end

        idle(6);
        check_eq("pending_drained", 32'(pend.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/median_3x3_merge.md
# median_3x3_merge

Downstream consumer of the registered 3-value sorter. Each cycle it may accept one column of a 3×3 window, already sorted high/mid/low, and keeps the last three columns. Once three columns are held it produces the 3×3 median with a two-edge pipeline, using the max-of-lows / median-of-mids / min-of-highs reduction. It sits between the column sorter and the pixel output stage of the median filter path.

## Interface

- DSIZE, 8, sample width in bits (unsigned)
- clock  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- in_valid  in  1  column present this cycle; mirrors the registered output timing of the upstream sorter
- in_sol  in  1  start of line; qualified by in_valid; this column becomes column 0 of a fresh window
- in_hi  in  DSIZE  largest value of the column (sorter outdata0)
- in_mid  in  DSIZE  middle value of the column (sorter outdata1)
- in_lo  in  DSIZE  smallest value of the column (sorter outdata2)
- out_valid  out  1  out_median (and out_min/out_max when enabled) is valid this cycle
- out_median  out  DSIZE  median of the 9 window values
- out_min  out  DSIZE  window minimum; present only with MEDIAN_MINMAX_EN
- out_max  out  DSIZE  window maximum; present only with MEDIAN_MINMAX_EN

## Operation

- Window: three column registers win[0..2], each holding hi/mid/lo. win[0] is the newest column.
- The column counter col_cnt is 2 bits wide and saturates at 3.
- Accepted column (in_valid=1):
  - Shift win[1]→win[2] and win[0]→win[1]; load the input into win[0].
  - If in_sol=1: col_cnt←1, so older columns are logically discarded. Register contents may remain, but they must not contribute to any output.
  - Otherwise col_cnt←min(col_cnt+1, 3).
  - The window is "full" when the updated col_cnt is 3; this sets v1 for the next stage.
- in_valid=0: window and col_cnt hold; in_sol is ignored.
- Stage 1 (registered), from the window:
  - A = max(lo0, lo1, lo2)
  - B = median(mid0, mid1, mid2)
  - C = min(hi0, hi1, hi2)
  - v2←v1.
- Stage 2 (registered): out_median = median(A, B, C); out_valid←v2.
- Comparison rule: a ≥ b is evaluated as !(a < b), unsigned, DSIZE bits. No arithmetic and no width growth.
- Input columns are assumed sorted. Unsorted input yields an undefined median, but must not produce X-propagation or a hang.
- In-flight results are never flushed by in_sol. A window completed before in_sol still produces its output.

## Timing

- Let t be the edge that captures the third (or later) column of a line. Stage 1 registers at t+1. out_valid=1 and the result are visible in the cycle after edge t+2. Latency is 2 edges from capture.
- Throughput: one result per accepted column once full, back-to-back with no bubbles.
- out_valid is a single-cycle pulse per result; there is no backpressure.
- Line of N columns (N ≥ 3) → exactly N−2 results. Lines with N < 3 produce none.
- Reset (rst=1 sampled at an edge):
  - col_cnt, v1, v2, out_valid, out_median, out_min and out_max all go to 0. Window registers also clear to 0.
  - Inputs are ignored while rst=1.
  - Reset mid-line drops all pending results. The first column after reset is treated as column 0 whether or not in_sol is set.
- in_sol with in_valid on the same edge as a completing window of the previous line is not possible. in_sol always starts a new count, and the previous line's last result was already latched one edge earlier.

## Configuration

- MEDIAN_MINMAX_EN defined:
  - Stage 1 additionally registers mn = min(lo0, lo1, lo2) and mx = max(hi0, hi1, hi2).
  - Stage 2 copies them to out_min and out_max, aligned with out_median and out_valid.
- MEDIAN_MINMAX_EN undefined: out_min, out_max and their registers do not exist; the port list omits them.

## Structure

- Package median_pkg:
  - DSIZE default
  - WIN_COLS=3
  - COL_CNT_W=2
  - typedef col_t (struct of hi/mid/lo, DSIZE each)
- One combinational sub-module sort3_net:
  - Takes 3 inputs, outputs max/med/min with the !(a<b) rule.
  - Instantiated for the lows, mids and highs in stage 1, and for A/B/C in stage 2.
  - Unused outputs are optimised away.

## Test plan

- Reset behaviour: rst held 3 cycles, then released with in_valid=0 → out_valid=0 and out_median=0 throughout; col_cnt=0.
- Basic median: in_sol with column (9,5,1), then (8,6,2), then (7,4,3) on consecutive cycles → one out_valid pulse 2 edges after the third capture with out_median=5. With MEDIAN_MINMAX_EN: out_min=1, out_max=9.
- Back-to-back results: a 5-column line of constant columns (4,4,4) → 3 consecutive out_valid pulses, each with out_median=4 (ties).
- Line restart: columns (9,5,1),(8,6,2), then in_sol with (3,3,3),(3,3,3) → no out_valid. A following (3,3,3) → out_median=3; old columns are excluded.
- Gaps: the line from the basic median scenario with in_valid=0 for 2 cycles between each column → out_median=5 once, 2 edges after the last capture; no extra pulses.
- Reset mid-flight: assert rst on the edge after the third column of the basic median scenario → no out_valid. A subsequent 3-column line without in_sol still yields its median.
